// File: rtl/pulse_restore_pkg.sv
// rtl/pulse_restore_pkg.sv - shared types, defaults and saturating increment for pulse_restore
package pulse_restore_pkg;

    localparam int DEFAULT_WIDTH_BITS = 8;
    localparam int DEFAULT_COUNT_BITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HIGH    = 2'd1,
        ST_HOLDOFF = 2'd2
    } pr_state_e;

    // Callers zero-extend to 32 bits and pass their all-ones ceiling; result is truncated back.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] ceiling);
        if (value >= ceiling) begin
            return value;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/pulse_restore_sync_bit.sv
// rtl/pulse_restore_sync_bit.sv - multi-flop synchroniser for one asynchronous bit
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_restore.sv
// rtl/pulse_restore.sv - resynchronise a stretched pulse, qualify its length and regenerate a strobe
module pulse_restore
    import pulse_restore_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH_BITS  = DEFAULT_WIDTH_BITS,
    parameter int COUNT_BITS  = DEFAULT_COUNT_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  longsignal,
    input  logic [WIDTH_BITS-1:0] minlength,
    input  logic [WIDTH_BITS-1:0] holdoff,
    input  logic                  clear_counters,
    output logic                  strobe,
    output logic [WIDTH_BITS-1:0] width,
    output logic                  width_valid,
    input  logic                  width_ready,
    output logic                  overflow,
    output logic [COUNT_BITS-1:0] eventcount,
    output logic [COUNT_BITS-1:0] rejectcount
);

    localparam logic [WIDTH_BITS-1:0] W_MAX = '1;
    localparam logic [WIDTH_BITS-1:0] W_ONE = WIDTH_BITS'(1);
    localparam logic [COUNT_BITS-1:0] C_MAX = '1;

    logic                  s;
    logic                  s_d_q;
    logic                  rise;
    logic [WIDTH_BITS-1:0] thr;

    pr_state_e             state_q,   state_d;
    logic [WIDTH_BITS-1:0] n_q,       n_d;
    logic [WIDTH_BITS-1:0] hcnt_q,    hcnt_d;
    logic                  strobe_q,  strobe_d;
    logic                  strobed_q, strobed_d;
    logic [WIDTH_BITS-1:0] width_q,   width_d;
    logic                  wvalid_q,  wvalid_d;
    logic                  ovf_q,     ovf_d;
    logic [COUNT_BITS-1:0] ev_q,      ev_d;
    logic [COUNT_BITS-1:0] rej_q,     rej_d;

    logic                  ev_inc;
    logic                  rej_inc;
    logic                  load;
    logic                  ovf_set;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (longsignal),
        .q_o   (s)
    );

    assign rise = s && !s_d_q;
    // minlength of 0 and 1 both mean any pulse qualifies.
    assign thr  = (minlength == '0) ? W_ONE : minlength;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_d_q     <= 1'b0;
            state_q   <= ST_IDLE;
            n_q       <= '0;
            hcnt_q    <= '0;
            strobe_q  <= 1'b0;
            strobed_q <= 1'b0;
            width_q   <= '0;
            wvalid_q  <= 1'b0;
            ovf_q     <= 1'b0;
            ev_q      <= '0;
            rej_q     <= '0;
        end else begin
            s_d_q     <= s;
            state_q   <= state_d;
            n_q       <= n_d;
            hcnt_q    <= hcnt_d;
            strobe_q  <= strobe_d;
            strobed_q <= strobed_d;
            width_q   <= width_d;
            wvalid_q  <= wvalid_d;
            ovf_q     <= ovf_d;
            ev_q      <= ev_d;
            rej_q     <= rej_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        hcnt_d    = hcnt_q;
        strobe_d  = 1'b0;
        strobed_d = strobed_q;
        width_d   = width_q;
        wvalid_d  = wvalid_q;
        ovf_d     = ovf_q;
        ev_d      = ev_q;
        rej_d     = rej_q;
        ev_inc    = 1'b0;
        rej_inc   = 1'b0;
        load      = 1'b0;
        ovf_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    n_d       = W_ONE;
                    state_d   = ST_HIGH;
                    strobed_d = 1'b0;
                    if (W_ONE >= thr) begin
                        strobe_d  = 1'b1;
                        strobed_d = 1'b1;
                    end
                end
            end
            ST_HIGH: begin
                if (s) begin
                    n_d = WIDTH_BITS'(sat_inc(32'(n_q), 32'(W_MAX)));
                    if (!strobed_q && (n_d >= thr)) begin
                        strobe_d  = 1'b1;
                        strobed_d = 1'b1;
                    end
                end else begin
                    if (n_q >= thr) begin
                        ev_inc = 1'b1;
                        load   = 1'b1;
                        // A threshold lowered on the final cycle still yields its one strobe.
                        if (!strobed_q) begin
                            strobe_d  = 1'b1;
                            strobed_d = 1'b1;
                        end
                    end else begin
                        rej_inc = 1'b1;
                    end
                    if (holdoff != '0) begin
                        state_d = ST_HOLDOFF;
                        hcnt_d  = W_ONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (rise) begin
                    rej_inc = 1'b1;
                end
                // >= so a holdoff lowered below the running count cannot strand the FSM.
                if (hcnt_q >= holdoff) begin
                    state_d = ST_IDLE;
                end else begin
                    hcnt_d = WIDTH_BITS'(sat_inc(32'(hcnt_q), 32'(W_MAX)));
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            if (wvalid_q && !width_ready) begin
                ovf_set = 1'b1;
            end else begin
                width_d  = n_q;
                wvalid_d = 1'b1;
            end
        end else if (wvalid_q && width_ready) begin
            wvalid_d = 1'b0;
        end

        if (clear_counters) begin
            ev_d  = '0;
            rej_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (ev_inc) begin
                ev_d = COUNT_BITS'(sat_inc(32'(ev_q), 32'(C_MAX)));
            end
            if (rej_inc) begin
                rej_d = COUNT_BITS'(sat_inc(32'(rej_q), 32'(C_MAX)));
            end
            if (ovf_set) begin
                ovf_d = 1'b1;
            end
        end
    end

    assign strobe      = strobe_q;
    assign width       = width_q;
    assign width_valid = wvalid_q;
    assign overflow    = ovf_q;
    assign eventcount  = ev_q;
    assign rejectcount = rej_q;

endmodule
